// File: rtl/issue_controller_pkg.sv
// rtl/issue_controller_pkg.sv - shared types, opcodes and control-op classification for the issue stage
package issue_controller_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;
    typedef logic [4:0]  regaddr_t;
    typedef logic [4:0]  oper_t;

    localparam oper_t OP_NOP  = 5'd0;
    localparam oper_t OP_ADD  = 5'd1;
    localparam oper_t OP_ADDI = 5'd2;
    localparam oper_t OP_SUB  = 5'd3;
    localparam oper_t OP_LUI  = 5'd4;
    localparam oper_t OP_LW   = 5'd5;
    localparam oper_t OP_SW   = 5'd6;
    localparam oper_t OP_JAL  = 5'd8;
    localparam oper_t OP_JALR = 5'd9;
    localparam oper_t OP_BEQ  = 5'd10;
    localparam oper_t OP_BNE  = 5'd11;
    localparam oper_t OP_BLT  = 5'd12;
    localparam oper_t OP_BGE  = 5'd13;
    localparam oper_t OP_BLTU = 5'd14;
    localparam oper_t OP_BGEU = 5'd15;

    localparam regaddr_t ZERO = 5'd0;

    // Width of the in-flight writer counter; holds up to 7.
    localparam int CNT_W = 3;

    typedef struct packed {
        addr_t    pc;
        oper_t    op;
        word_t    imm;
        logic     en_rx;
        logic     en_ry;
        logic     en_w;
        regaddr_t rx;
        regaddr_t ry;
        regaddr_t rd;
    } instr_t;

    // Ops that redirect fetch and must be resolved before anything younger issues.
    function automatic logic is_ctrl_op(oper_t op);
        case (op)
            OP_JAL, OP_JALR,
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/issue_if.sv
// rtl/issue_if.sv - valid/ready instruction channel between pipeline stages
interface issue_if;
    import issue_controller_pkg::*;

    logic     valid;
    logic     ready;
    addr_t    pc;
    oper_t    op;
    word_t    imm;
    logic     en_rx;
    logic     en_ry;
    logic     en_w;
    regaddr_t rx;
    regaddr_t ry;
    regaddr_t rd;

    modport master (output valid, pc, op, imm, en_rx, en_ry, en_w, rx, ry, rd, input ready);
    modport slave  (input valid, pc, op, imm, en_rx, en_ry, en_w, rx, ry, rd, output ready);
endinterface

// File: rtl/issue_controller_scoreboard.sv
// rtl/issue_controller_scoreboard.sv - per-register busy bits and outstanding writer counter
module issue_scoreboard
    import issue_controller_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     rdy,
    input  logic     en_rx,
    input  logic     en_ry,
    input  logic     en_w,
    input  regaddr_t rx,
    input  regaddr_t ry,
    input  regaddr_t rd,
    input  logic     issue,
    input  logic     wb_valid,
    input  regaddr_t wb_rd,
    output logic     hazard,
    output logic     full
);

    logic [31:0]      busy_q, busy_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             writer, set_w, clr_w;

    assign writer = en_w & (rd != ZERO);
    assign hazard = (en_rx & busy_q[rx]) | (en_ry & busy_q[ry]) | (en_w & busy_q[rd]);
    assign full   = writer & (count_q == CNT_W'(MAX_INFLIGHT));
    assign set_w  = issue & writer;
    // x0 is never busy, so writebacks to x0 or idle registers fall out here.
    assign clr_w  = wb_valid & busy_q[wb_rd];

    // Next busy vector and count; a same-cycle set and clear cancel in the counter.
    always_comb begin
        busy_d = busy_q;
        if (clr_w) busy_d[wb_rd] = 1'b0;
        if (set_w) busy_d[rd]    = 1'b1;
        busy_d[0] = 1'b0;
        count_d = count_q;
        if (set_w && !clr_w)      count_d = count_q + CNT_W'(1);
        else if (!set_w && clr_w) count_d = count_q - CNT_W'(1);
    end

    // Scoreboard state, frozen while rdy is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            count_q <= '0;
        end else if (rdy) begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/issue_controller.sv
// rtl/issue_controller.sv - hazard-checked issue stage with branch wait and registered output
module issue_controller
    import issue_controller_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     rdy,
    issue_if.slave   dec,
    issue_if.master  exe,
    input  logic     wb_valid,
    input  regaddr_t wb_rd,
    input  logic     br_valid,
    input  logic     br_taken,
    output logic     flush
);

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_WAIT_BR = 1'b1;

    logic [0:0] state_q;
    logic       out_valid_q;
    instr_t     out_q;
    instr_t     in_instr;
    logic       hazard, full, issue, resolve;

    assign in_instr = '{pc: dec.pc, op: dec.op, imm: dec.imm, en_rx: dec.en_rx,
                        en_ry: dec.en_ry, en_w: dec.en_w, rx: dec.rx, ry: dec.ry, rd: dec.rd};

    issue_scoreboard #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .rdy      (rdy),
        .en_rx    (dec.en_rx),
        .en_ry    (dec.en_ry),
        .en_w     (dec.en_w),
        .rx       (dec.rx),
        .ry       (dec.ry),
        .rd       (dec.rd),
        .issue    (issue),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .hazard   (hazard),
        .full     (full)
    );

    assign issue   = (state_q == ST_RUN) & rdy & dec.valid & ~hazard & ~full
                   & (~out_valid_q | exe.ready);
    assign resolve = (state_q == ST_WAIT_BR) & rdy & br_valid;
    assign flush   = resolve & br_taken;
    // A taken branch consumes the wrong-path instruction without issuing it.
    assign dec.ready = issue | (flush & dec.valid);

    // Stop issuing behind a control op until execute resolves it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else if (rdy) begin
            if (issue && is_ctrl_op(dec.op)) state_q <= ST_WAIT_BR;
            else if (resolve)                state_q <= ST_RUN;
        end
    end

    // Output stage: load on issue, drain when execute takes it, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (rdy) begin
            if (issue) begin
                out_valid_q <= 1'b1;
                out_q       <= in_instr;
            end else if (exe.ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign exe.valid = out_valid_q;
    assign exe.pc    = out_q.pc;
    assign exe.op    = out_q.op;
    assign exe.imm   = out_q.imm;
    assign exe.en_rx = out_q.en_rx;
    assign exe.en_ry = out_q.en_ry;
    assign exe.en_w  = out_q.en_w;
    assign exe.rx    = out_q.rx;
    assign exe.ry    = out_q.ry;
    assign exe.rd    = out_q.rd;

endmodule

// File: doc/issue_controller.md
# issue_controller

Sits between the instruction decoder and the execute stage and decides every cycle whether the decoded instruction may issue. Uses a per-register busy scoreboard to block RAW/WAW hazards and caps the number of outstanding register writers. After a control-flow op (branch/JAL/JALR) it stops issuing until execute resolves it, and on a taken branch it discards the wrong-path instruction. Issued instructions are held in a registered valid/ready output stage feeding execute.

## Interface
- MAX_INFLIGHT, default 4: maximum issued, not-yet-written-back register writers (1..7).
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rdy  in  1  global enable; when 0 every register holds.
- in_valid  in  1  decoder holds a decoded instruction.
- in_ready  out  1  instruction accepted this cycle (issued or discarded).
- in_pc  in  `addr_t  instruction PC.
- in_op  in  `oper_t  decoded operation.
- in_imm  in  `word_t  immediate.
- in_en_rx, in_en_ry, in_en_w  in  1 each  source x / source y / destination in use.
- in_rx, in_ry, in_rd  in  `regaddr_t each  register addresses.
- out_valid  out  1  issued instruction present.
- out_ready  in  1  execute accepts.
- out_pc, out_op, out_imm, out_rx, out_ry, out_rd, out_en_w  out  as inputs  registered copy of the issued instruction.
- wb_valid  in  1  a register write completes.
- wb_rd  in  `regaddr_t  register being written back.
- br_valid  in  1  control op resolved.
- br_taken  in  1  resolved op redirects fetch (qualified by br_valid).
- flush  out  1  one-cycle pulse: wrong-path instruction discarded.

## Operation
- Scoreboard busy[31:0]; busy[0] constant 0.
- hazard = (in_en_rx & busy[in_rx]) | (in_en_ry & busy[in_ry]) | (in_en_w & busy[in_rd]).
- writer = in_en_w & (in_rd != 0); full = writer & (count == MAX_INFLIGHT).
- States: RUN, WAIT_BR.
- RUN: issue = rdy & in_valid & ~hazard & ~full & (~out_valid | out_ready). in_ready = issue. On issue: output stage loads input, out_valid=1; if writer, set busy[in_rd], count+1; if in_op is OP_JAL, OP_JALR or any branch op -> WAIT_BR.
- WAIT_BR: no issue. On rdy & br_valid: -> RUN; if br_taken, flush=1 and in_ready=in_valid (input dropped, scoreboard untouched).
- Writeback: rdy & wb_valid & busy[wb_rd] clears the bit, count-1. wb to a non-busy register or x0 is ignored.
- Simultaneous issue-set and writeback-clear on same register cannot occur (WAW stalls); simultaneous increment and decrement leaves count unchanged.
- Output stage: out_valid clears when out_ready & ~issue; data held while out_valid & ~out_ready.
- rdy=0: state, scoreboard, count, output stage hold; in_ready=0, flush=0; wb/br inputs ignored.

## Timing
- Reset: state RUN, busy 0, count 0, out_valid 0, all out_* data 0, flush 0.
- Issue latency 1: accepted at edge N, visible on out_* after N.
- Scoreboard is registered, no bypass: writeback at edge N frees a dependent instruction for acceptance in the cycle after N (issue at edge N+1 at the earliest).
- in_ready may depend combinationally on in_* data and out_ready; no registered output depends combinationally on inputs except in_ready and flush.
- br_valid arriving in RUN is ignored.
- Reset mid-operation drops the output stage and all scoreboard state immediately.

## Structure
- Shared defines package: `addr_t, `word_t, `oper_t, `regaddr_t, OP_* codes, ZERO, and a control-op classification macro listing JAL, JALR, BEQ..BGEU.
- One sub-module: issue_scoreboard (busy bits, set/clear ports, two read plus one write check, in-flight counter).

## Test plan
- Back-to-back independent ADDI x1, x2 with out_ready=1 -> issue every cycle, busy[1], busy[2] set, count=2.
- ADDI x5 then ADD x6,x5,x5 -> second held (in_ready=0) until wb x5; issues one cycle after the wb edge.
- MAX_INFLIGHT=4, five writers with no wb -> fifth stalls; one wb -> fifth issues next cycle, count=4.
- BEQ issued, then br_valid=1, br_taken=1 with in_valid=1 -> flush pulse, input dropped, state RUN, no busy change; with br_taken=0 the next instruction issues after resolution.
- out_ready=0 for 3 cycles -> out_* stable, in_ready=0; rdy=0 mid-stream freezes everything including wb.
- Reset asserted with out_valid=1 and busy[7]=1 -> out_valid=0, busy 0, count 0 immediately.
